// File: rtl/vdma_sched_pkg.sv
// Shared types and the lowest-free-buffer search for the frame-buffer scheduler.
// Used by frame_buf_sched (optional FRAME_BUF_SCHED_STAT_EN build macro lives there).
package vdma_sched_pkg;

    localparam int DROP_W   = 16;
    localparam int MAX_NBUF = 16;
    localparam int MAX_PW   = 4;

    typedef logic [MAX_PW-1:0] buf_idx_t;

    typedef struct packed {
        logic     found;
        buf_idx_t idx;
    } free_sel_t;

    // Scan from the top down so the last hit is the lowest clear bit.
    function automatic free_sel_t first_free(input logic [MAX_NBUF-1:0] busy);
        free_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = '0;
        for (int i = MAX_NBUF - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                sel.found = 1'b1;
                sel.idx   = buf_idx_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Single-bit vsync rising-edge detector; the edge is valid in the cycle
// that first samples vs high.
module vs_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic vs_edge
);

    logic vs_q;
    logic vs_d;

    always_comb begin
        vs_d = vs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign vs_edge = vs & ~vs_q;

endmodule

// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler: one writer, RDPORT readers, NBUF buffers.
// Define FRAME_BUF_SCHED_STAT_EN to implement the drop_cnt statistic (else tied to 0).
module frame_buf_sched
    import vdma_sched_pkg::*;
#(
    parameter int NBUF   = 3,
    parameter int RDPORT = 2,
    parameter int PW     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_enable,
    input  logic                   wr_vs,
    input  logic [RDPORT-1:0]      rd_vs,
    output logic [PW-1:0]          wr_base,
    output logic [RDPORT*PW-1:0]   rd_base,
    output logic [RDPORT-1:0]      rd_valid,
    output logic [DROP_W-1:0]      drop_cnt
);

    logic                 wr_edge;
    logic [RDPORT-1:0]    rd_edge;

    logic [PW-1:0]        wr_base_q, wr_base_d;
    logic [PW-1:0]        latest_q, latest_d;
    logic                 latest_valid_q, latest_valid_d;
    logic [RDPORT*PW-1:0] rd_base_q, rd_base_d;
    logic [RDPORT-1:0]    rd_valid_q, rd_valid_d;

    logic                 commit;
    logic [PW-1:0]        eff_latest;
    logic [MAX_NBUF-1:0]  busy;
    free_sel_t            free_sel;
    logic                 free_ok;

    vs_edge_det u_wr_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .vs      (wr_vs),
        .vs_edge (wr_edge)
    );

    for (genvar g = 0; g < RDPORT; g++) begin : g_rd_edge
        vs_edge_det u_rd_edge (
            .clk     (clk),
            .rst_n   (rst_n),
            .vs      (rd_vs[g]),
            .vs_edge (rd_edge[g])
        );
    end

    // A reader latching in the same cycle as a commit gets the just-finished frame.
    always_comb begin
        commit     = wr_edge & wr_enable;
        eff_latest = commit ? wr_base_q : latest_q;
        rd_base_d  = rd_base_q;
        rd_valid_d = rd_valid_q;
        for (int i = 0; i < RDPORT; i++) begin
            if (rd_edge[i] && (latest_valid_q || commit)) begin
                rd_base_d[i*PW +: PW] = eff_latest;
                rd_valid_d[i]         = 1'b1;
            end
        end
    end

    // Busy uses post-update reader holdings; out-of-range slots are always busy.
    always_comb begin
        busy = '1;
        for (int j = 0; j < NBUF; j++) begin
            busy[j] = (wr_base_q == PW'(j));
            for (int i = 0; i < RDPORT; i++) begin
                if (rd_valid_d[i] && (rd_base_d[i*PW +: PW] == PW'(j))) begin
                    busy[j] = 1'b1;
                end
            end
        end
        free_sel = first_free(busy);
        free_ok  = free_sel.found && (int'(free_sel.idx) < NBUF);
    end

    always_comb begin
        wr_base_d      = wr_base_q;
        latest_d       = latest_q;
        latest_valid_d = latest_valid_q;
        if (commit) begin
            latest_d       = wr_base_q;
            latest_valid_d = 1'b1;
            if (free_ok) begin
                wr_base_d = free_sel.idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_base_q      <= '0;
            latest_q       <= '0;
            latest_valid_q <= 1'b0;
            rd_base_q      <= '0;
            rd_valid_q     <= '0;
        end else begin
            wr_base_q      <= wr_base_d;
            latest_q       <= latest_d;
            latest_valid_q <= latest_valid_d;
            rd_base_q      <= rd_base_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

`ifdef FRAME_BUF_SCHED_STAT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of committed frames that found no free successor buffer.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (commit && !free_ok && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign wr_base  = wr_base_q;
    assign rd_base  = rd_base_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Scoreboard bench for frame_buf_sched (NBUF=3, RDPORT=2, PW=2); drop expectation
// follows FRAME_BUF_SCHED_STAT_EN.
module tb_frame_buf_sched;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        wr_enable = 1'b0;
    logic        wr_vs     = 1'b0;
    logic [1:0]  rd_vs     = 2'b00;
    logic [1:0]  wr_base;
    logic [3:0]  rd_base;
    logic [1:0]  rd_valid;
    logic [15:0] drop_cnt;

`ifdef FRAME_BUF_SCHED_STAT_EN
    localparam logic [15:0] DROP_ONE = 16'd1;
`else
    localparam logic [15:0] DROP_ONE = 16'd0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  wr;
        logic [1:0]  rd0;
        logic [1:0]  rd1;
        logic [1:0]  rv;
        logic [15:0] drop;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    frame_buf_sched #(.NBUF(3), .RDPORT(2), .PW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_enable (wr_enable),
        .wr_vs     (wr_vs),
        .rd_vs     (rd_vs),
        .wr_base   (wr_base),
        .rd_base   (rd_base),
        .rd_valid  (rd_valid),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp({e.name, ".wr_base"},  16'(wr_base),      16'(e.wr));
        cmp({e.name, ".rd_base0"}, 16'(rd_base[1:0]), 16'(e.rd0));
        cmp({e.name, ".rd_base1"}, 16'(rd_base[3:2]), 16'(e.rd1));
        cmp({e.name, ".rd_valid"}, 16'(rd_valid),     16'(e.rv));
        cmp({e.name, ".drop_cnt"}, drop_cnt,          e.drop);
    endtask

    // Monitor: pops an expectation once the DUT has had its update edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            e = exp_q.pop_front();
            checkOutput(e);
        end
    end

    task automatic pushExp(input string name, input logic [1:0] wr, input logic [1:0] rd0,
                           input logic [1:0] rd1, input logic [1:0] rv, input logic [15:0] drop);
        exp_t e;
        e.name = name; e.wr = wr; e.rd0 = rd0; e.rd1 = rd1; e.rv = rv; e.drop = drop;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // One-cycle vsync pulse on the selected sources, then queue the expected outputs.
    task automatic applyStimulus(input logic w, input logic [1:0] r, input string name,
                                 input logic [1:0] wr, input logic [1:0] rd0, input logic [1:0] rd1,
                                 input logic [1:0] rv, input logic [15:0] drop);
        @(negedge clk);
        wr_vs = w;
        rd_vs = r;
        @(negedge clk);
        wr_vs = 1'b0;
        rd_vs = 2'b00;
        pushExp(name, wr, rd0, rd1, rv, drop);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pushExp("reset", 2'd0, 2'd0, 2'd0, 2'b00, 16'd0);

        applyStimulus(1'b0, 2'b01, "rd_before_commit", 2'd0, 2'd0, 2'd0, 2'b00, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_disabled_a",    2'd0, 2'd0, 2'd0, 2'b00, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_disabled_b",    2'd0, 2'd0, 2'd0, 2'b00, 16'd0);

        @(negedge clk);
        wr_enable = 1'b1;
        applyStimulus(1'b1, 2'b00, "wr_pulse1", 2'd1, 2'd0, 2'd0, 2'b00, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_pulse2", 2'd0, 2'd0, 2'd0, 2'b00, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_pulse3", 2'd1, 2'd0, 2'd0, 2'b00, 16'd0);

        applyStimulus(1'b0, 2'b01, "rd0_latch",    2'd1, 2'd0, 2'd0, 2'b01, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_skip_held", 2'd2, 2'd0, 2'd0, 2'b01, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_back_to_1", 2'd1, 2'd0, 2'd0, 2'b01, 16'd0);

        applyStimulus(1'b1, 2'b01, "wr_rd_same_cycle", 2'd0, 2'd1, 2'd0, 2'b01, 16'd0);

        applyStimulus(1'b0, 2'b10, "rd1_latch",   2'd0, 2'd1, 2'd1, 2'b11, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_to_2",     2'd2, 2'd1, 2'd1, 2'b11, 16'd0);
        applyStimulus(1'b0, 2'b10, "rd1_relatch", 2'd2, 2'd1, 2'd0, 2'b11, 16'd0);
        applyStimulus(1'b1, 2'b00, "wr_drop",     2'd2, 2'd1, 2'd0, 2'b11, DROP_ONE);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pushExp("mid_reset", 2'd0, 2'd0, 2'd0, 2'b00, 16'd0);
        applyStimulus(1'b1, 2'b00, "post_reset_wr", 2'd1, 2'd0, 2'd0, 2'b00, 16'd0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
